// File: rtl/sync_fifo_burst_rd_if.sv
// FIFO read port plus output beat stream for sync_fifo_burst_rd.
// master = the read engine, slave = the FIFO/consumer side.
interface sync_fifo_burst_rd_if #(
  parameter int WD = 8,
  parameter int AW = 4
);
  // Stream handshake: a beat transfers on a rising clk edge where m_valid && m_ready.
  // While m_valid && !m_ready, m_data and m_last stay unchanged.
  // fifo_rd_en pops the show-ahead head (fifo_rd_data) on the same edge.
  logic          fifo_empty;
  logic [AW:0]   fifo_occupancy;
  logic [WD-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [WD-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  modport master (
    input  fifo_empty, fifo_occupancy, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_occupancy, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sync_fifo_burst_rd.sv
// Burst read engine: drains a show-ahead FIFO in fixed-length bursts, or
// flushes partial content after an idle timeout, onto a registered stream.
module sync_fifo_burst_rd #(
  parameter int WD = 8,
  parameter int DP = 16,
  parameter int AW = $clog2(DP),
  parameter int TW = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sreset_n,
  input  logic                 enable,
  input  logic [AW:0]          cfg_burst_len,
  input  logic [TW-1:0]        cfg_timeout,
  sync_fifo_burst_rd_if.master bus,
  output logic                 busy,
  output logic                 flush_evt,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LEN_DP  = (AW+1)'(DP);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);

  state_t        state;
  logic [AW:0]   beat_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [AW:0]   len_eff;
  logic          pop;
  logic          start_burst;
  logic          start_flush;
  logic          m_valid_q;
  logic          m_last_q;
  logic [WD-1:0] m_data_q;
  logic          busy_q;
  logic          flush_evt_q;

  always_comb begin
    len_eff = cfg_burst_len;
    if (cfg_burst_len == '0) begin
      len_eff = LEN_ONE;
    end else if (cfg_burst_len > LEN_DP) begin
      len_eff = LEN_DP;
    end
  end

  // beat_cnt is latched from occupancy at entry, so a pop can never hit an empty FIFO.
  assign pop         = (state != IDLE) && (beat_cnt != '0) && (!m_valid_q || bus.m_ready);
  assign start_burst = enable && (bus.fifo_occupancy >= len_eff);
  assign start_flush = enable && (cfg_timeout != '0) && !bus.fifo_empty &&
                       (tmo_cnt >= (cfg_timeout - TMO_ONE));

  assign bus.fifo_rd_en = pop;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_last     = m_last_q;
  assign busy           = busy_q;
  assign flush_evt      = flush_evt_q;
  assign dbg_state      = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      tmo_cnt     <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
      flush_evt_q <= 1'b0;
    end else if (!sreset_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      tmo_cnt     <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
      flush_evt_q <= 1'b0;
    end else begin
      flush_evt_q <= 1'b0;

      if (pop) begin
        m_data_q  <= bus.fifo_rd_data;
        m_valid_q <= 1'b1;
        m_last_q  <= (beat_cnt == LEN_ONE);
      end else if (bus.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end

      case (state)
        IDLE: begin
          // A full burst wins over a timeout flush in the same cycle.
          if (start_burst) begin
            state    <= BURST;
            beat_cnt <= len_eff;
            tmo_cnt  <= '0;
            busy_q   <= 1'b1;
          end else if (start_flush) begin
            state       <= FLUSH;
            beat_cnt    <= bus.fifo_occupancy;
            tmo_cnt     <= '0;
            busy_q      <= 1'b1;
            flush_evt_q <= 1'b1;
          end else if (bus.fifo_empty) begin
            tmo_cnt <= '0;
          end else if (enable && (tmo_cnt != '1)) begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
          end
        end
        default: begin
          if (pop) begin
            beat_cnt <= beat_cnt - LEN_ONE;
            if (beat_cnt == LEN_ONE) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule
